// File: rtl/instr_dispatch_fsm_if.sv
// Bundle of the dispatcher's fetch bus, execution-unit start/done lines and
// status outputs. "master" is the dispatcher side; "slave" is the side that
// drives instructions and completions and watches the status.
interface instr_dispatch_fsm_if #(
  parameter int IW        = 16,
  parameter int NUM_UNITS = 4
);
  logic                 run;
  logic                 fetch_req;
  logic                 fetch_ack;
  logic [IW-1:0]        instr_in;
  logic [IW-1:0]        ir;
  logic [NUM_UNITS-1:0] start;
  logic [NUM_UNITS-1:0] done;
  logic                 busy;
  logic                 halted;
  logic                 err;
  logic [1:0]           err_code;
  logic [7:0]           instr_count;

  modport master (
    input  run, fetch_ack, instr_in, done,
    output fetch_req, ir, start, busy, halted, err, err_code, instr_count
  );

  modport slave (
    output run, fetch_ack, instr_in, done,
    input  fetch_req, ir, start, busy, halted, err, err_code, instr_count
  );
endinterface

// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatch sequencer: fetches a word over req/ack, decodes the
// opcode, pulses start to one execution unit and waits for its done pulse.
// Flags illegal opcodes, execution timeouts and a halt opcode. All outputs
// are decoded from registered state only.
module instr_dispatch_fsm #(
  parameter int             IW        = 16,
  parameter int             OPW       = 4,
  parameter int             NUM_UNITS = 4,
  parameter int             TIMEOUT   = 64,
  parameter logic [OPW-1:0] HALT_OP   = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_dispatch_fsm_if.master bus
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LP_TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_ir;
  logic [UW-1:0]   r_unit;
  logic [CW-1:0]   r_tmo_cnt;
  logic [1:0]      r_err_code;
  logic [7:0]      r_instr_count;

  logic [OPW-1:0]       w_opcode;
  logic                 w_op_is_unit;
  logic                 w_op_is_halt;
  logic                 w_unit_done;
  logic                 w_tmo_hit;
  logic [NUM_UNITS-1:0] w_start;

  assign w_opcode     = r_ir[IW-1 -: OPW];
  assign w_op_is_unit = int'(w_opcode) < NUM_UNITS;
  assign w_op_is_halt = (w_opcode == HALT_OP);
  // Only the unit that was issued can complete the instruction.
  assign w_unit_done  = bus.done[r_unit];
  assign w_tmo_hit    = (r_tmo_cnt == LP_TMO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch forms.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.run) w_state_next = S_FETCH;
      S_FETCH:  if (bus.fetch_ack) w_state_next = S_DECODE;
      S_DECODE: begin
        if (w_op_is_unit)      w_state_next = S_ISSUE;
        else if (w_op_is_halt) w_state_next = S_HALT;
        else                   w_state_next = S_ERR;
      end
      S_ISSUE:  w_state_next = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over a timeout hitting in the same cycle.
        if (w_unit_done)    w_state_next = bus.run ? S_FETCH : S_IDLE;
        else if (w_tmo_hit) w_state_next = S_ERR;
      end
      S_HALT:   if (!bus.run) w_state_next = S_IDLE;
      S_ERR:    w_state_next = S_ERR;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Instruction register, unit select, timeout counter, error code, count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir          <= '0;
      r_unit        <= '0;
      r_tmo_cnt     <= '0;
      r_err_code    <= 2'b00;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (bus.fetch_ack) r_ir <= bus.instr_in;
        S_DECODE: begin
          if (w_op_is_unit) r_unit <= w_opcode[UW-1:0];
          else if (!w_op_is_halt) r_err_code <= 2'b01;
        end
        S_ISSUE: r_tmo_cnt <= '0;
        S_WAIT: begin
          if (w_unit_done) begin
            r_instr_count <= r_instr_count + 8'd1;
            r_tmo_cnt     <= '0;
          end else if (w_tmo_hit) begin
            r_err_code <= 2'b10;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // One-hot start pulse, present only during the single ISSUE cycle.
  always_comb begin
    w_start = '0;
    if (r_state == S_ISSUE) w_start[r_unit] = 1'b1;
  end

  assign bus.fetch_req   = (r_state == S_FETCH);
  assign bus.start       = w_start;
  assign bus.busy        = !(r_state inside {S_IDLE, S_HALT, S_ERR});
  assign bus.halted      = (r_state == S_HALT);
  assign bus.err         = (r_state == S_ERR);
  assign bus.err_code    = r_err_code;
  assign bus.ir          = r_ir;
  assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Self-checking bench for instr_dispatch_fsm: directed scenarios plus
// randomized instructions, latencies and noise, checked against a
// per-instruction behavioural expectation derived from the opcode.
module tb_instr_dispatch_fsm;

  localparam int IW        = 16;
  localparam int NUM_UNITS = 4;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  instr_dispatch_fsm_if #(.IW(IW), .NUM_UNITS(NUM_UNITS)) bus ();

  instr_dispatch_fsm #(
    .IW(IW), .OPW(4), .NUM_UNITS(NUM_UNITS), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: completed-instruction count and latched word.
  int          exp_count = 0;
  logic [15:0] exp_ir    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string ctx);
    check({ctx, "/fetch_req"},   bus.fetch_req,   0);
    check({ctx, "/start"},       bus.start,       0);
    check({ctx, "/busy"},        bus.busy,        0);
    check({ctx, "/halted"},      bus.halted,      0);
    check({ctx, "/err"},         bus.err,         0);
    check({ctx, "/err_code"},    bus.err_code,    0);
    check({ctx, "/ir"},          bus.ir,          0);
    check({ctx, "/instr_count"}, bus.instr_count, 0);
  endtask

  task automatic do_reset();
    bus.run       = 1'b0;
    bus.fetch_ack = 1'b0;
    bus.done      = '0;
    bus.instr_in  = '0;
    reset         = 1'b1;
    tick();
    reset         = 1'b0;
    exp_count     = 0;
    exp_ir        = '0;
    check_reset_vals("reset");
  endtask

  // Runs one instruction, starting at a sample point where fetch_req is
  // expected high. done_lat: WAIT cycle index (0 = first WAIT cycle) in which
  // done is raised, -1 for never. reset_at: WAIT cycle index to apply reset.
  task automatic run_instr(input logic [15:0] w, input int ack_lat, input int done_lat,
                           input bit noise, input bit run_after, input int reset_at);
    int         op;
    logic [3:0] onehot;
    op     = int'(w[15:12]);
    onehot = 4'(1 << (op % NUM_UNITS));

    check("fetch_req", bus.fetch_req, 1);
    for (int i = 0; i < ack_lat; i++) begin
      tick();
      check("fetch_req_hold", bus.fetch_req, 1);
      check("ir_hold", bus.ir, exp_ir);
    end
    bus.fetch_ack = 1'b1;
    bus.instr_in  = w;
    tick();
    bus.fetch_ack = 1'b0;
    bus.instr_in  = 16'($urandom);
    exp_ir        = w;
    check("ir_latch", bus.ir, exp_ir);
    check("decode_req", bus.fetch_req, 0);
    check("decode_start", bus.start, 0);
    check("decode_busy", bus.busy, 1);
    tick();

    if (op == 15) begin
      check("halt_halted", bus.halted, 1);
      check("halt_busy", bus.busy, 0);
      check("halt_start", bus.start, 0);
      check("halt_err", bus.err, 0);
      return;
    end
    if (op >= NUM_UNITS) begin
      check("ill_err", bus.err, 1);
      check("ill_code", bus.err_code, 1);
      check("ill_busy", bus.busy, 0);
      check("ill_start", bus.start, 0);
      return;
    end

    check("issue_start", bus.start, onehot);
    check("issue_busy", bus.busy, 1);
    if (noise) bus.done = '1;
    tick();
    bus.done = '0;
    check("wait_start", bus.start, 0);
    check("wait_req", bus.fetch_req, 0);
    check("wait_err", bus.err, 0);

    for (int k = 0; k < TIMEOUT; k++) begin
      if (k == reset_at) begin
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_count = 0;
        exp_ir    = '0;
        check_reset_vals("wait_reset");
        return;
      end
      if (k == done_lat) begin
        bus.fetch_ack = 1'b0;
        bus.done      = onehot;
        bus.run       = run_after;
        tick();
        bus.done  = '0;
        exp_count = (exp_count + 1) % 256;
        check("done_count", bus.instr_count, exp_count);
        check("done_req", bus.fetch_req, run_after);
        check("done_busy", bus.busy, run_after);
        check("done_err", bus.err, 0);
        if (!run_after) begin
          bus.run = 1'b1;
          tick();
          check("idle_to_fetch", bus.fetch_req, 1);
        end
        return;
      end
      if (noise) begin
        bus.done      = (4'($urandom) | 4'b0001) & ~onehot;
        bus.fetch_ack = 1'($urandom_range(0, 1));
        bus.instr_in  = 16'($urandom);
      end
      tick();
      bus.done      = '0;
      bus.fetch_ack = 1'b0;
      if (k == TIMEOUT - 1) begin
        check("tmo_err", bus.err, 1);
        check("tmo_code", bus.err_code, 2);
        check("tmo_busy", bus.busy, 0);
        check("tmo_start", bus.start, 0);
      end else begin
        check("wait_err_k", bus.err, 0);
        check("wait_busy_k", bus.busy, 1);
        check("wait_req_k", bus.fetch_req, 0);
        check("wait_start_k", bus.start, 0);
        check("wait_ir_k", bus.ir, exp_ir);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    reset = 1'b1;
    do_reset();
    tick();
    check("idle_stay_req", bus.fetch_req, 0);
    check("idle_stay_busy", bus.busy, 0);

    // First instruction: unit 0, ack one cycle late, done 5 cycles after start.
    bus.run = 1'b1;
    tick();
    run_instr(16'h0123, 1, 4, 1'b0, 1'b1, -1);
    check("first_count", bus.instr_count, 1);

    // Back-to-back, with stray done bits from other units in the second WAIT.
    run_instr(16'h1000, 0, 2, 1'b0, 1'b1, -1);
    run_instr(16'h3000, 0, 6, 1'b1, 1'b1, -1);

    // done in the very cycle the timeout would hit.
    run_instr(16'h2abc, 0, TIMEOUT - 1, 1'b0, 1'b1, -1);

    // Randomized legal instructions.
    repeat (40) begin
      w = {2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
      run_instr(w, $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 12),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // Reset while waiting on a unit.
    run_instr(16'h1555, 0, -1, 1'b0, 1'b1, 5);
    tick();
    check("post_reset_fetch", bus.fetch_req, 1);

    // 256 completions wrap the counter back to zero.
    repeat (256) run_instr({2'b00, 2'($urandom_range(0, 3)), 12'h0}, 0, 0, 1'b0, 1'b1, -1);
    check("wrap_count", bus.instr_count, 0);

    // Halt opcode, then leave HALT through run.
    run_instr(16'hF000, 0, 0, 1'b0, 1'b1, -1);
    repeat (3) begin
      tick();
      check("halt_hold", bus.halted, 1);
      check("halt_hold_req", bus.fetch_req, 0);
    end
    bus.run = 1'b0;
    tick();
    check("halt_exit_halted", bus.halted, 0);
    check("halt_exit_busy", bus.busy, 0);
    check("halt_exit_req", bus.fetch_req, 0);
    bus.run = 1'b1;
    tick();
    check("halt_refetch", bus.fetch_req, 1);

    // Unit 2 never answers: timeout error, which is sticky.
    run_instr(16'h2000, 0, -1, 1'b0, 1'b1, -1);
    repeat (5) begin
      bus.run       = 1'($urandom_range(0, 1));
      bus.fetch_ack = 1'($urandom_range(0, 1));
      bus.done      = 4'($urandom);
      tick();
      check("tmo_sticky_err", bus.err, 1);
      check("tmo_sticky_code", bus.err_code, 2);
      check("tmo_sticky_start", bus.start, 0);
    end

    // Illegal opcode: error 01, no start, sticky until reset.
    do_reset();
    bus.run = 1'b1;
    tick();
    run_instr(16'h7000, 0, 0, 1'b0, 1'b1, -1);
    repeat (5) begin
      bus.done = 4'($urandom);
      tick();
      check("ill_sticky_err", bus.err, 1);
      check("ill_sticky_code", bus.err_code, 1);
      check("ill_sticky_start", bus.start, 0);
    end
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_dispatch_fsm.md
Name: instr_dispatch_fsm

Overview:
- Top-level sequencer that drives the per-instruction execution FSMs (mov, add, etc.) from the initiator side of the start/done handshake.
- Fetches an instruction word through a req/ack handshake, latches it and decodes its opcode.
- Pulses `start` to exactly one execution unit, then waits for that unit's `done` pulse before fetching the next instruction.
- Detects illegal opcodes, execution timeouts and a halt opcode.

Parameters:
- IW, 16, instruction word width; the opcode is `ir[IW-1:IW-OPW]`.
- OPW, 4, opcode field width.
- NUM_UNITS, 4, number of execution FSMs; opcode value k < NUM_UNITS selects unit k.
- TIMEOUT, 64, maximum cycles spent in WAIT before a timeout error.
- HALT_OP, 4'hF, opcode value that halts the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enables fetch/execute; sampled in IDLE, WAIT (on completion) and HALT.
- fetch_req  out  1  instruction fetch request.
- fetch_ack  in  1  fetch acknowledge; `instr_in` is valid in the same cycle.
- instr_in  in  IW  instruction word from instruction memory.
- ir  out  IW  latched instruction register.
- start  out  NUM_UNITS  one-hot, single-cycle start pulse to the execution FSMs.
- done  in  NUM_UNITS  per-unit completion pulses.
- busy  out  1  high in every state except IDLE, HALT and ERR.
- halted  out  1  high in HALT.
- err  out  1  high in ERR.
- err_code  out  2  error cause: 00 none, 01 illegal opcode, 10 timeout.
- instr_count  out  8  count of completed instructions; wraps 255 -> 0.

Behaviour:
- Reset: synchronous, active-high, priority over all else. On reset:
  - state = IDLE; `fetch_req`, `start`, `busy`, `halted`, `err` = 0.
  - `err_code` = 00, `ir` = 0, `instr_count` = 0, timeout counter = 0.
- Output timing: Moore. All outputs are decoded from registered state or registers; there is no combinational path from any input to any output.
- IDLE:
  - run = 1 -> FETCH next cycle; otherwise stay.
- FETCH:
  - `fetch_req` = 1, held until `fetch_ack`.
  - On the `fetch_ack` = 1 cycle: `ir` <= `instr_in`; -> DECODE.
  - `fetch_ack` seen in any other state is ignored.
- DECODE (1 cycle):
  - opcode < NUM_UNITS -> ISSUE, selected unit latched.
  - opcode == HALT_OP -> HALT.
  - otherwise -> ERR with `err_code` 01.
- ISSUE (1 cycle):
  - `start[unit]` = 1, all other start bits 0; -> WAIT.
  - `done` is ignored in this cycle.
- WAIT:
  - Timeout counter increments each cycle.
  - On `done[unit]` = 1: `instr_count` += 1, counter cleared; -> FETCH if run = 1, else IDLE.
  - `done` from non-selected units is ignored.
  - Counter reaching TIMEOUT-1 without `done` -> ERR with `err_code` 10.
  - If `done[unit]` arrives in the same cycle the timeout hits, `done` wins: the instruction completes with no error.
- HALT:
  - `halted` = 1; stays until run = 0, then -> IDLE.
- ERR:
  - `err` = 1, `err_code` held; exits only on reset.
- Minimum instruction period: FETCH 1 + DECODE 1 + ISSUE 1 + WAIT n cycles.
- Reset mid-WAIT: `start` is forced low immediately. The execution units are reset by the same reset, so no stale `done` is tracked.
- `start` is never asserted for more than one cycle, and never for more than one unit.

Test Plan:
- Reset, run = 1, ack 1 cycle after req, `instr_in` = 16'h0123 (unit 0), `done[0]` pulsed 5 cycles after `start[0]`:
  - `start` = 4'b0001 for exactly one cycle.
  - `instr_count` = 1.
  - `fetch_req` reasserts the cycle after `done`.
- Back-to-back instructions 16'h1000 then 16'h3000:
  - `start` = 4'b0010, then 4'b1000.
  - `instr_count` = 2.
  - A stray `done[0]` during the second WAIT is ignored.
- `instr_in` = 16'h7000 with NUM_UNITS = 4:
  - ERR, `err` = 1, `err_code` = 01, `start` never asserted.
  - Stays in ERR until reset.
- Issue to unit 2, `done` never returned:
  - ERR with `err_code` = 10 exactly TIMEOUT cycles after entering WAIT.
  - `busy` = 0.
- `instr_in` = 16'hF000:
  - `halted` = 1, `busy` = 0.
  - run dropped -> IDLE; run raised -> FETCH next cycle.
- Edge cases:
  - Assert reset while in WAIT: all outputs return to reset values on the next edge.
  - `done` coincident with the timeout cycle: completes normally, `err` stays 0.
  - 256 completed instructions: `instr_count` wraps to 0.
